seq_divider: RTL

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Sequential restoring divider, one quotient bit per cycle.
//               Optional two's-complement mode works on operand magnitudes
//               and applies the result signs in a final fix-up cycle.
//
// Parameters  : WIDTH       operand/result width in bits (4..64)
//               SIGNED_EN   0 forces unsigned operation (signed_mode ignored)
//
// Ports       : clk          clock, rising edge
//               rst          synchronous active-high reset
//               start        request pulse, accepted only in IDLE
//               signed_mode  1 = two's-complement operands (sampled with start)
//               dividend     numerator (sampled with start)
//               divisor      denominator (sampled with start)
//               busy         high while the iteration / fix-up is running
//               done         one-cycle pulse, results valid
//               quotient     result quotient (held until next accepted start)
//               remainder    result remainder (held until next accepted start)
//               div_by_zero  set with done when the divisor was zero
//
// Revision    : 1.0  initial release
// ============================================================================
module seq_divider #(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int                c_cnt_w = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_iter = c_cnt_w'(WIDTH);
    localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_rem;     // settled remainder, always < divisor
    logic [WIDTH-1:0]   r_quo;     // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0]   r_div;     // divisor magnitude
    logic               r_neg_q;
    logic               r_neg_r;

    // ------------------------------------------------------------------------
    // Operand magnitudes at the start request
    // ------------------------------------------------------------------------
    logic             w_sgn;
    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;

    // The most-negative value negates to itself, which read as unsigned is
    // exactly its magnitude, so no special case is needed.
    assign w_sgn     = SIGNED_EN & signed_mode;
    assign w_dvd_neg = w_sgn & dividend[WIDTH-1];
    assign w_dvs_neg = w_sgn & divisor[WIDTH-1];
    assign w_dvd_mag = w_dvd_neg ? -dividend : dividend;
    assign w_dvs_mag = w_dvs_neg ? -divisor  : divisor;

    // ------------------------------------------------------------------------
    // Restoring shift-subtract step on a WIDTH+1-bit partial remainder
    // ------------------------------------------------------------------------
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_borrow;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;

    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_div};

    // w_shift < 2*divisor always holds.  Without a borrow the difference is
    // below the divisor so its top bit is clear; with a borrow the wrapped
    // result is above 2^WIDTH so its top bit is set.  That bit is the borrow.
    assign w_borrow   = w_diff[WIDTH];
    assign w_rem_next = w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign w_quo_next = {r_quo[WIDTH-2:0], ~w_borrow};

    // ------------------------------------------------------------------------
    // Sign fix-up
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

    assign w_q_fix = r_neg_q ? -r_quo : r_quo;
    assign w_r_fix = r_neg_r ? -r_rem : r_rem;

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_div       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            // Skip the iteration entirely; busy never rises.
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_quo       <= w_dvd_mag;
                            r_div       <= w_dvs_mag;
                            r_rem       <= '0;
                            r_neg_q     <= w_dvd_neg ^ w_dvs_neg;
                            r_neg_r     <= w_dvd_neg;
                            r_cnt       <= c_iter;
                            div_by_zero <= 1'b0;
                            busy        <= 1'b1;
                            r_state     <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt - c_one;
                    if (r_cnt == c_one) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    quotient  <= w_q_fix;
                    remainder <= w_r_fix;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    r_state   <= S_DONE;
                end
                S_DONE: begin
                    // A start arriving here is deliberately dropped.
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
